scoreboard_register_file: RTL and testbench

//  Parametrised successor to the 32x32 MIPS register file, built for the pipelined datapath.
//  Two combinational read ports with write-through bypass; one write (writeback) port; hardwired zero register.

---
 rtl/scoreboard_register_file_pkg.sv | 12 +
 rtl/scoreboard_register_file_pending_counter.sv | 42 ++++
 rtl/scoreboard_register_file.sv | 116 +++++++++++
 tb/tb_scoreboard_register_file.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/scoreboard_register_file_pkg.sv
// Shared register-file definitions: architectural register indices and default widths
// used by the scoreboarded register file and its per-register pending counters.
package scoreboard_register_file_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_ADDR_WIDTH = 5;

    localparam int REG_ZERO = 0;
    localparam int REG_SP   = 29;
    localparam int REG_RA   = 31;

endpackage

// File: rtl/scoreboard_register_file_pending_counter.sv
// Outstanding-write counter for one architectural register. Flush clears it; a
// simultaneous issue and writeback cancel out; writebacks never underflow it.
module reg_pending_counter #(
    parameter int CNT_WIDTH = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc_i,
    input  logic                 dec_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o,
    output logic                 sat_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && dec_i) begin
            cnt_d = cnt_q;
        end else if (inc_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign sat_o = (cnt_q == '1);

endmodule

// File: rtl/scoreboard_register_file.sv
// Pipelined-datapath register file: two bypassed combinational read ports, one
// writeback port, hardwired r0, and a per-register scoreboard that flags read hazards.
module scoreboard_register_file
    import scoreboard_register_file_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int CNT_WIDTH  = 2,
    parameter bit BYPASS     = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  reg_write_i,
    input  logic [ADDR_WIDTH-1:0] write_register_i,
    input  logic [DATA_WIDTH-1:0] write_data_i,
    input  logic [ADDR_WIDTH-1:0] read_register_1_i,
    input  logic [ADDR_WIDTH-1:0] read_register_2_i,
    output logic [DATA_WIDTH-1:0] read_data_1_o,
    output logic [DATA_WIDTH-1:0] read_data_2_o,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_register_i,
    output logic                  issue_ready_o,
    input  logic                  flush_i,
    output logic                  hazard_1_o,
    output logic                  hazard_2_o
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]   wr_en;

    logic [NUM_REGS-1:0][CNT_WIDTH-1:0] cnt;
    logic [NUM_REGS-1:0]                sat;

    // Writeback, issue and flush are all ignored while reset is held.
    logic wb_live;
    logic issue_accept;
    logic issue_hits_wb;
    logic wbk_1;
    logic wbk_2;

    assign wb_live       = reset & reg_write_i;
    assign issue_hits_wb = reg_write_i & (write_register_i == issue_register_i);
    assign issue_ready_o = ~sat[issue_register_i] | issue_hits_wb
                         | (issue_register_i == ZERO_ADDR);
    assign issue_accept  = reset & issue_valid_i & issue_ready_o
                         & (issue_register_i != ZERO_ADDR);

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            wr_en[r]  = wb_live && (r != REG_ZERO) && (write_register_i == ADDR_WIDTH'(r));
            regs_d[r] = wr_en[r] ? write_data_i : regs_q[r];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    assign cnt[0] = '0;
    assign sat[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_pending
        reg_pending_counter #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_cnt (
            .clk  (clk),
            .rst_n(reset),
            .inc_i(issue_accept & (issue_register_i == ADDR_WIDTH'(r))),
            .dec_i(wb_live & (write_register_i == ADDR_WIDTH'(r))),
            .clr_i(flush_i),
            .cnt_o(cnt[r]),
            .sat_o(sat[r])
        );
    end

    function automatic logic [DATA_WIDTH-1:0] read_mux(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic                  bypass_hit,
        input logic [DATA_WIDTH-1:0] wdata,
        input logic [DATA_WIDTH-1:0] stored
    );
        if (addr == ZERO_ADDR) begin
            return '0;
        end else if (bypass_hit) begin
            return wdata;
        end
        return stored;
    endfunction

    assign wbk_1 = BYPASS & wb_live & (write_register_i == read_register_1_i);
    assign wbk_2 = BYPASS & wb_live & (write_register_i == read_register_2_i);

    assign read_data_1_o = read_mux(read_register_1_i, wbk_1, write_data_i,
                                    regs_q[read_register_1_i]);
    assign read_data_2_o = read_mux(read_register_2_i, wbk_2, write_data_i,
                                    regs_q[read_register_2_i]);

    // A bypassed writeback retires one outstanding write, so only count beyond it stalls.
    assign hazard_1_o = (read_register_1_i != ZERO_ADDR)
                      & (cnt[read_register_1_i] > CNT_WIDTH'(wbk_1));
    assign hazard_2_o = (read_register_2_i != ZERO_ADDR)
                      & (cnt[read_register_2_i] > CNT_WIDTH'(wbk_2));

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed plus randomized bench for scoreboard_register_file, checked against an
// array/counter reference model of the register-file and scoreboard rules.
module tb_scoreboard_register_file;

    localparam int MAXC = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        reg_write_i = 1'b0;
    logic [4:0]  write_register_i = '0;
    logic [31:0] write_data_i = '0;
    logic [4:0]  read_register_1_i = '0;
    logic [4:0]  read_register_2_i = '0;
    logic        issue_valid_i = 1'b0;
    logic [4:0]  issue_register_i = '0;
    logic        flush_i = 1'b0;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        hz1_b, hz2_b, hz1_n, hz2_n, rdy_b, rdy_n;

    int total  = 0;
    int passed = 0;
    int fails  = 0;

    logic [31:0] mem [32];
    int          pend [32];

    always #5 clk = ~clk;

    scoreboard_register_file #(.BYPASS(1'b1)) dut (
        .clk(clk), .reset(reset), .reg_write_i(reg_write_i),
        .write_register_i(write_register_i), .write_data_i(write_data_i),
        .read_register_1_i(read_register_1_i), .read_register_2_i(read_register_2_i),
        .read_data_1_o(rd1_b), .read_data_2_o(rd2_b),
        .issue_valid_i(issue_valid_i), .issue_register_i(issue_register_i),
        .issue_ready_o(rdy_b), .flush_i(flush_i),
        .hazard_1_o(hz1_b), .hazard_2_o(hz2_b)
    );

    scoreboard_register_file #(.BYPASS(1'b0)) dut_nb (
        .clk(clk), .reset(reset), .reg_write_i(reg_write_i),
        .write_register_i(write_register_i), .write_data_i(write_data_i),
        .read_register_1_i(read_register_1_i), .read_register_2_i(read_register_2_i),
        .read_data_1_o(rd1_n), .read_data_2_o(rd2_n),
        .issue_valid_i(issue_valid_i), .issue_register_i(issue_register_i),
        .issue_ready_o(rdy_n), .flush_i(flush_i),
        .hazard_1_o(hz1_n), .hazard_2_o(hz2_n)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_read(input int a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && reset && reg_write_i && write_register_i == 5'(a)) return write_data_i;
        return mem[a];
    endfunction

    function automatic logic m_hazard(input int a, input bit byp);
        int retiring;
        retiring = (byp && reset && reg_write_i && write_register_i == 5'(a)) ? 1 : 0;
        return (a != 0) && (pend[a] - retiring > 0);
    endfunction

    function automatic logic m_ready();
        return (pend[issue_register_i] < MAXC) || issue_register_i == 0
            || (reg_write_i && write_register_i == issue_register_i);
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 32; r++) begin
            mem[r]  = '0;
            pend[r] = 0;
        end
    endtask

    task automatic model_update();
        bit accept;
        accept = issue_valid_i && m_ready() && issue_register_i != 0;
        for (int r = 1; r < 32; r++) begin
            bit iss, wb;
            iss = accept && issue_register_i == 5'(r);
            wb  = reg_write_i && write_register_i == 5'(r);
            if (flush_i)               pend[r] = 0;
            else if (iss && wb)        pend[r] = pend[r];
            else if (iss)              pend[r] = pend[r] + 1;
            else if (wb && pend[r] > 0) pend[r] = pend[r] - 1;
        end
        if (reg_write_i && write_register_i != 0) mem[write_register_i] = write_data_i;
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_update();
        else model_clear();
        #1;
    endtask

    task automatic check_all(input string tag);
        int a1, a2;
        a1 = int'(read_register_1_i);
        a2 = int'(read_register_2_i);
        chk({tag, ".rd1"},   rd1_b, m_read(a1, 1'b1));
        chk({tag, ".rd2"},   rd2_b, m_read(a2, 1'b1));
        chk({tag, ".hz1"},   32'(hz1_b), 32'(m_hazard(a1, 1'b1)));
        chk({tag, ".hz2"},   32'(hz2_b), 32'(m_hazard(a2, 1'b1)));
        chk({tag, ".rdy"},   32'(rdy_b), 32'(m_ready()));
        chk({tag, ".nb_rd1"}, rd1_n, m_read(a1, 1'b0));
        chk({tag, ".nb_rd2"}, rd2_n, m_read(a2, 1'b0));
        chk({tag, ".nb_hz1"}, 32'(hz1_n), 32'(m_hazard(a1, 1'b0)));
        chk({tag, ".nb_hz2"}, 32'(hz2_n), 32'(m_hazard(a2, 1'b0)));
        chk({tag, ".nb_rdy"}, 32'(rdy_n), 32'(m_ready()));
    endtask

    task automatic idle_inputs();
        reg_write_i   = 1'b0;
        issue_valid_i = 1'b0;
        flush_i       = 1'b0;
    endtask

    initial begin
        model_clear();
        // Reset held: everything reads zero with no hazard
        repeat (2) @(posedge clk);
        #1;
        for (int r = 0; r < 32; r++) begin
            read_register_1_i = 5'(r);
            read_register_2_i = 5'(31 - r);
            #1;
            check_all("reset_read");
            chk("reset_rd1_zero", rd1_b, 32'h0);
        end
        chk("reset_ready", 32'(rdy_b), 32'h1);
        #2 reset = 1'b1;
        tick();

        // Write to r0 dropped; write to r8 visible next cycle
        reg_write_i = 1'b1; write_register_i = 5'd0; write_data_i = 32'hDEADBEEF;
        tick();
        write_register_i = 5'd8; write_data_i = 32'h12345678;
        tick();
        idle_inputs();
        read_register_1_i = 5'd0; read_register_2_i = 5'd8;
        #1;
        check_all("r0_r8");
        chk("r0_zero", rd1_b, 32'h0);
        chk("r8_data", rd2_b, 32'h12345678);

        // Same-cycle write and read of r9
        reg_write_i = 1'b1; write_register_i = 5'd9; write_data_i = 32'hA5A5A5A5;
        read_register_1_i = 5'd9;
        #1;
        check_all("bypass_r9");
        chk("bypass_on", rd1_b, 32'hA5A5A5A5);
        chk("bypass_off_old", rd1_n, 32'h0);
        tick();
        idle_inputs();

        // Saturate r10, then drain with three writebacks
        issue_valid_i = 1'b1; issue_register_i = 5'd10;
        for (int i = 0; i < 3; i++) begin
            #1; check_all("issue_r10"); tick();
        end
        #1;
        check_all("issue_r10_full");
        chk("r10_not_ready", 32'(rdy_b), 32'h0);
        tick();
        idle_inputs();
        read_register_1_i = 5'd10;
        for (int i = 0; i < 3; i++) begin
            reg_write_i = 1'b1; write_register_i = 5'd10; write_data_i = 32'h100 + 32'(i);
            #1;
            check_all("drain_r10");
            chk("drain_r10_hz", 32'(hz1_b), (i < 2) ? 32'h1 : 32'h0);
            tick();
        end
        idle_inputs();
        #1;
        chk("r10_after_hz", 32'(hz1_b), 32'h0);
        chk("r10_after_data", rd1_b, 32'h102);

        // Issue+writeback cancel on r11, then flush
        issue_valid_i = 1'b1; issue_register_i = 5'd11;
        tick();
        reg_write_i = 1'b1; write_register_i = 5'd11; write_data_i = 32'h0B0B0B0B;
        tick();
        idle_inputs();
        read_register_1_i = 5'd11;
        #1;
        check_all("r11_cancel");
        chk("r11_hz_persist", 32'(hz1_b), 32'h1);
        flush_i = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("r11_after_flush", 32'(hz1_b), 32'h0);

        // Reset mid-sequence on r12
        write_register_i = 5'd12; write_data_i = 32'hC0FFEE00; reg_write_i = 1'b1;
        tick();
        reg_write_i = 1'b0;
        issue_valid_i = 1'b1; issue_register_i = 5'd12;
        tick(); tick();
        issue_valid_i = 1'b0; read_register_1_i = 5'd12;
        #1;
        chk("r12_hz_before", 32'(hz1_b), 32'h1);
        reset = 1'b0;
        #1;
        model_clear();
        check_all("r12_reset");
        chk("r12_hz_reset", 32'(hz1_b), 32'h0);
        chk("r12_data_reset", rd1_b, 32'h0);
        #1 reset = 1'b1;
        issue_valid_i = 1'b1;
        #1;
        chk("r12_post_ready", 32'(rdy_b), 32'h1);
        tick();
        idle_inputs();
        #1;
        chk("r12_post_hz", 32'(hz1_b), 32'h1);

        // Randomized traffic concentrated on a few registers
        for (int c = 0; c < 400; c++) begin
            reg_write_i       = ($urandom_range(0, 2) == 0);
            write_register_i  = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'($urandom_range(0, 5));
            write_data_i      = $urandom;
            issue_valid_i     = ($urandom_range(0, 1) == 1);
            issue_register_i  = 5'($urandom_range(0, 5));
            read_register_1_i = 5'($urandom_range(0, 5));
            read_register_2_i = ($urandom_range(0, 3) == 0) ? 5'(scoreboard_register_file_pkg::REG_RA)
                                                            : 5'($urandom_range(0, 5));
            flush_i           = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) begin
                reset = 1'b0;
                #1;
                model_clear();
                check_all("rand_reset");
                reset = 1'b1;
                #1;
            end
            #1;
            check_all("rand");
            tick();
        end
        idle_inputs();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
